tt_um_chandrakanth_gate_tester: RTL and testbench



---
 rtl/tt_um_chandrakanth_gate_tester.sv | 144 ++++++++++++++
 tb/tb_tt_um_chandrakanth_gate_tester.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_chandrakanth_gate_tester.sv
// Sequential stimulus/checker for 2-input logic tiles: steps A/B through all four
// vectors, samples the gate response after a settle window and reports pass/fail.
module tt_um_chandrakanth_gate_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic [1:0]    drive;
  logic [2:0]    sel_q;
  logic          loopback_q;
  logic [3:0]    fail_mask;
  logic          busy;
  logic          done;
  logic          restart;
  logic          oe_en;

  logic start_meta, start_sync, start_prev;
  logic y_meta, y_sync;
  logic start_rise;
  logic y_src;
  logic start_ok;

  // Expected truth table of the selected gate for a given (A,B).
  function automatic logic expected_y(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      3'd0:    y = ~(a & b);
      3'd1:    y = a & b;
      3'd2:    y = a | b;
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      3'd6:    y = ~a;
      default: y = a;
    endcase
    return y;
  endfunction

  assign start_rise = start_sync & ~start_prev;
  assign start_ok   = start_rise & ((state == IDLE) | ((state == DONE) & ~restart));
  assign y_src      = loopback_q ? ~(drive[0] & drive[1]) : uio_in[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_meta <= 1'b0;
      start_sync <= 1'b0;
      start_prev <= 1'b0;
      y_meta     <= 1'b0;
      y_sync     <= 1'b0;
    end else begin
      start_meta <= ui_in[0];
      start_sync <= start_meta;
      start_prev <= start_sync;
      y_meta     <= y_src;
      y_sync     <= y_meta;
    end
  end

  // Main sequencer; loop mode is sampled on each DONE entry so it can be stopped live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      drive      <= 2'd0;
      sel_q      <= 3'd0;
      loopback_q <= 1'b0;
      fail_mask  <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      restart    <= 1'b0;
      oe_en      <= 1'b0;
    end else begin
      oe_en <= 1'b1;
      if (start_ok) begin
        sel_q      <= ui_in[3:1];
        loopback_q <= ui_in[5];
        fail_mask  <= 4'd0;
        done       <= 1'b0;
        busy       <= 1'b1;
        drive      <= 2'd0;
        settle_cnt <= '0;
        state      <= DRIVE;
      end else begin
        case (state)
          DRIVE: begin
            if (settle_cnt == SETTLE_LAST) begin
              state <= SAMPLE;
            end else begin
              settle_cnt <= settle_cnt + CW'(1);
            end
          end
          SAMPLE: begin
            if (y_sync != expected_y(sel_q, drive[0], drive[1])) begin
              fail_mask[drive] <= 1'b1;
            end
            if (drive != 2'd3) begin
              drive      <= drive + 2'd1;
              settle_cnt <= '0;
              state      <= DRIVE;
            end else begin
              drive   <= 2'd0;
              done    <= 1'b1;
              restart <= ui_in[4];
              busy    <= ui_in[4];
              state   <= DONE;
            end
          end
          DONE: begin
            if (restart) begin
              restart    <= 1'b0;
              drive      <= 2'd0;
              settle_cnt <= '0;
              state      <= DRIVE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign uo_out  = {fail_mask, done & (fail_mask != 4'd0), done & (fail_mask == 4'd0), done, busy};
  assign uio_out = {6'd0, drive};
  assign uio_oe  = {6'd0, oe_en, oe_en};

  logic _unused;
  assign _unused = &{1'b0, ena, ui_in[7:6], uio_in[7:3], uio_in[1:0]};

endmodule

// File: tb/tb_tt_um_chandrakanth_gate_tester.sv
// Directed bench for the gate tester: loopback, external-gate, loop-mode and reset scenarios.
module tb_tt_um_chandrakanth_gate_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ext_stuck;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // External gate model: NOR of the driven pins, optionally stuck at 0.
  assign uio_in = {5'd0, ext_stuck ? 1'b0 : ~(uio_out[0] | uio_out[1]), 2'd0};

  tt_um_chandrakanth_gate_tester #(.SETTLE_CYCLES(4)) dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  // Launch a run with the given config and measure busy length and vector stepping.
  task automatic do_run(input logic [7:0] cfg, output int cycles, output int step_errs);
    int w;
    cycles = 0;
    step_errs = 0;
    w = 0;
    @(negedge clk);
    ui_in = {cfg[7:1], 1'b0};
    repeat (3) @(negedge clk);
    ui_in[0] = 1'b1;
    while (!uo_out[0] && w < 10) begin
      @(negedge clk);
      w++;
    end
    while (uo_out[0] && cycles < 100) begin
      if (uio_out[1:0] != 2'(cycles / 5)) step_errs++;
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ui_in = 8'h00;
    ext_stuck = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (uo_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_uo_out: got %h want 00", uo_out); end
    compared++;
    if (uio_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_uio_out: got %h want 00", uio_out); end
    compared++;
    if (uio_oe !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_uio_oe: got %h want 00", uio_oe); end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (uio_oe !== 8'h03) begin mismatched++; $display("[TB] FAIL release_uio_oe: got %h want 03", uio_oe); end
  endtask

  task automatic test_nand_loopback;
    int cycles, step_errs;
    do_run(8'h20, cycles, step_errs);
    compared++;
    if (cycles !== 20) begin mismatched++; $display("[TB] FAIL nand_busy_len: got %0d want 20", cycles); end
    compared++;
    if (step_errs !== 0) begin mismatched++; $display("[TB] FAIL nand_vector_steps: got %0d bad want 0", step_errs); end
    compared++;
    if (uo_out !== 8'h06) begin mismatched++; $display("[TB] FAIL nand_status: got %h want 06", uo_out); end
    compared++;
    if (uio_out !== 8'h00) begin mismatched++; $display("[TB] FAIL nand_idle_drive: got %h want 00", uio_out); end
  endtask

  task automatic test_select_mismatch;
    int cycles, step_errs;
    do_run(8'h24, cycles, step_errs);
    compared++;
    if (cycles !== 20) begin mismatched++; $display("[TB] FAIL or_busy_len: got %0d want 20", cycles); end
    compared++;
    if (uo_out !== 8'h9A) begin mismatched++; $display("[TB] FAIL or_status: got %h want 9a", uo_out); end
    do_run(8'h22, cycles, step_errs);
    compared++;
    if (cycles !== 20) begin mismatched++; $display("[TB] FAIL and_busy_len: got %0d want 20", cycles); end
    compared++;
    if (uo_out !== 8'hFA) begin mismatched++; $display("[TB] FAIL and_status: got %h want fa", uo_out); end
  endtask

  task automatic test_external;
    int cycles, step_errs;
    ext_stuck = 1'b0;
    do_run(8'h06, cycles, step_errs);
    compared++;
    if (cycles !== 20) begin mismatched++; $display("[TB] FAIL ext_nor_busy_len: got %0d want 20", cycles); end
    compared++;
    if (uo_out !== 8'h06) begin mismatched++; $display("[TB] FAIL ext_nor_status: got %h want 06", uo_out); end
    // NOR expects 1,0,0,0; a stuck-low response only disagrees on v0.
    ext_stuck = 1'b1;
    do_run(8'h06, cycles, step_errs);
    compared++;
    if (uo_out !== 8'h1A) begin mismatched++; $display("[TB] FAIL ext_stuck_status: got %h want 1a", uo_out); end
    ext_stuck = 1'b0;
  endtask

  task automatic test_loop_mode;
    int w, bad;
    @(negedge clk);
    ui_in = 8'h30;
    repeat (3) @(negedge clk);
    ui_in = 8'h31;
    w = 0;
    while (!(uo_out[0] && !uo_out[1]) && w < 10) begin @(negedge clk); w++; end
    w = 0;
    while (!uo_out[1] && w < 40) begin @(negedge clk); w++; end
    compared++;
    if (uo_out !== 8'h07) begin mismatched++; $display("[TB] FAIL loop_first_done: got %h want 07", uo_out); end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) ui_in = 8'h33;
      @(negedge clk);
      if (uo_out[0] !== 1'b1 || uo_out[1] !== 1'b1 || uo_out[3] !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin mismatched++; $display("[TB] FAIL loop_running: got %0d bad cycles want 0", bad); end
    ui_in[4] = 1'b0;
    w = 0;
    while (uo_out[0] && w < 40) begin @(negedge clk); w++; end
    compared++;
    if (uo_out !== 8'h06) begin mismatched++; $display("[TB] FAIL loop_stop_status: got %h want 06", uo_out); end
  endtask

  task automatic test_back_to_back;
    int cycles, w;
    @(negedge clk);
    ui_in = 8'h20;
    repeat (3) @(negedge clk);
    ui_in[0] = 1'b1;
    w = 0;
    while (!uo_out[0] && w < 10) begin @(negedge clk); w++; end
    cycles = 0;
    while (uo_out[0] && cycles < 100) begin
      if (cycles == 3) ui_in[0] = 1'b0;
      if (cycles == 10) ui_in[0] = 1'b1;
      cycles++;
      @(negedge clk);
    end
    compared++;
    if (cycles !== 20) begin mismatched++; $display("[TB] FAIL b2b_busy_len: got %0d want 20", cycles); end
    repeat (6) @(negedge clk);
    compared++;
    if (uo_out !== 8'h06) begin mismatched++; $display("[TB] FAIL b2b_no_restart: got %h want 06", uo_out); end
  endtask

  task automatic test_reset_midrun;
    int w, cycles, step_errs;
    @(negedge clk);
    ui_in = 8'h20;
    repeat (3) @(negedge clk);
    ui_in[0] = 1'b1;
    w = 0;
    while (!(uo_out[0] && uio_out[1:0] == 2'd2) && w < 40) begin @(negedge clk); w++; end
    compared++;
    if (uio_out !== 8'h02) begin mismatched++; $display("[TB] FAIL midrun_reach_v2: got %h want 02", uio_out); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (uo_out !== 8'h00) begin mismatched++; $display("[TB] FAIL midrun_rst_uo_out: got %h want 00", uo_out); end
    compared++;
    if (uio_out !== 8'h00) begin mismatched++; $display("[TB] FAIL midrun_rst_uio_out: got %h want 00", uio_out); end
    compared++;
    if (uio_oe !== 8'h00) begin mismatched++; $display("[TB] FAIL midrun_rst_uio_oe: got %h want 00", uio_oe); end
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_run(8'h20, cycles, step_errs);
    compared++;
    if (cycles !== 20) begin mismatched++; $display("[TB] FAIL rerun_busy_len: got %0d want 20", cycles); end
    compared++;
    if (step_errs !== 0) begin mismatched++; $display("[TB] FAIL rerun_vector_steps: got %0d bad want 0", step_errs); end
    compared++;
    if (uo_out !== 8'h06) begin mismatched++; $display("[TB] FAIL rerun_status: got %h want 06", uo_out); end
  endtask

  initial begin
    test_reset();
    test_nand_loopback();
    test_select_mismatch();
    test_external();
    test_loop_mode();
    test_back_to_back();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
